intdiv_iter: RTL and testbench

INTDIV_ITER -- requirements
Module: intdiv_iter

---
 rtl/intdiv_iter.sv | 112 +++++++++++
 tb/tb_intdiv_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/intdiv_iter.sv
// Iterative radix-2 restoring integer divider, DIVCOPIES steps per cycle.
// Signed or unsigned, returns quotient or remainder; divide-by-zero completes immediately.
module intdiv_iter #(
   parameter int XLEN      = 32,
   parameter int DIVCOPIES = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Start,
   input  logic            Signed,
   input  logic            RemOp,
   input  logic [XLEN-1:0] X,
   input  logic [XLEN-1:0] D,
   input  logic            Flush,
   output logic            Busy,
   output logic            Done,
   output logic [XLEN-1:0] Result
);

   localparam int N  = XLEN / DIVCOPIES;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state;
   logic [XLEN-1:0] w, xq, dabsb;
   logic            signed_q, remop_q, signx, signd;
   logic [CW-1:0]   cnt;

   logic [XLEN-1:0] xabs, dabs;
   logic [XLEN-1:0] wc  [DIVCOPIES+1];
   logic [XLEN-1:0] xqc [DIVCOPIES+1];
   logic [XLEN:0]   wsh [DIVCOPIES];
   logic [XLEN+1:0] sum [DIVCOPIES];
   logic [DIVCOPIES-1:0] unused_summsb;
   logic [XLEN-1:0] qfin, rfin, resfin;

   assign xabs = (Signed & X[XLEN-1]) ? -X : X;
   assign dabs = (Signed & D[XLEN-1]) ? -D : D;

   // Shifted partial remainder needs XLEN+1 bits since |D| may reach 2^XLEN-1;
   // after the restore/subtract choice it always fits back into XLEN bits.
   always_comb begin
      wc[0]  = w;
      xqc[0] = xq;
      unused_summsb = '0;
      for (int unsigned i = 0; i < DIVCOPIES; i++) begin
         wsh[i] = {wc[i], xqc[i][XLEN-1]};
         sum[i] = {1'b0, wsh[i]} + {2'b01, dabsb} + (XLEN+2)'(1);
         unused_summsb[i] = sum[i][XLEN];
         wc[i+1]  = sum[i][XLEN+1] ? sum[i][XLEN-1:0] : wsh[i][XLEN-1:0];
         xqc[i+1] = {xqc[i][XLEN-2:0], sum[i][XLEN+1]};
      end
   end

   assign qfin   = xqc[DIVCOPIES];
   assign rfin   = wc[DIVCOPIES];
   assign resfin = remop_q ? ((signed_q & signx) ? -rfin : rfin)
                           : ((signed_q & (signx ^ signd)) ? -qfin : qfin);

   assign Busy = (state == BUSY);
   assign Done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         Result   <= '0;
         w        <= '0;
         xq       <= '0;
         dabsb    <= '0;
         signed_q <= 1'b0;
         remop_q  <= 1'b0;
         signx    <= 1'b0;
         signd    <= 1'b0;
      end else if (Flush) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: if (Start) begin
               signed_q <= Signed;
               remop_q  <= RemOp;
               signx    <= Signed & X[XLEN-1];
               signd    <= Signed & D[XLEN-1];
               w        <= '0;
               xq       <= xabs;
               dabsb    <= ~dabs;
               cnt      <= '0;
               if (D == '0) begin
                  state  <= DONE;
                  Result <= RemOp ? X : '1;
               end else begin
                  state <= BUSY;
               end
            end
            BUSY: begin
               w   <= wc[DIVCOPIES];
               xq  <= xqc[DIVCOPIES];
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= DONE;
                  Result <= resfin;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intdiv_iter.sv
// Directed self-checking bench for intdiv_iter (XLEN=32, DIVCOPIES=4).
module tb_intdiv_iter;

   logic        clk = 1'b0;
   logic        reset, Start, Signed, RemOp, Flush;
   logic [31:0] X, D;
   logic        Busy, Done;
   logic [31:0] Result;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   intdiv_iter #(.XLEN(32), .DIVCOPIES(4)) dut (
      .clk(clk), .reset(reset), .Start(Start), .Signed(Signed), .RemOp(RemOp),
      .X(X), .D(D), .Flush(Flush), .Busy(Busy), .Done(Done), .Result(Result)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, scrambles X/D after acceptance, and waits (bounded) for Done.
   task automatic run_div(input logic s, input logic rm, input logic [31:0] x, input logic [31:0] d,
                          output int busyc, output int donec, output logic [31:0] res);
      Signed = s; RemOp = rm; X = x; D = d; Start = 1'b1;
      tick();
      Start = 1'b0;
      X = 32'hDEADBEEF; D = 32'h00000005;
      busyc = 0; donec = 0; res = 'x;
      for (int c = 1; c <= 20 && donec == 0; c++) begin
         if (Done) begin
            donec = c;
            res = Result;
         end else begin
            if (Busy) busyc++;
            tick();
         end
      end
      if (donec != 0) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; Start = 1'b1; Flush = 1'b0; Signed = 1'b0; RemOp = 1'b0; X = 32'd100; D = 32'd7;
      tick(); tick();
      total++; if (Busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", Busy); else passed++;
      total++; if (Done !== 1'b0) $display("FAIL reset_done got=%b exp=0", Done); else passed++;
      total++; if (Result !== 32'h0) $display("FAIL reset_result got=%h exp=0", Result); else passed++;
      Start = 1'b0; reset = 1'b0;
      tick();
   endtask

   task automatic test_unsigned();
      int b, dn; logic [31:0] r;
      run_div(1'b0, 1'b0, 32'd100, 32'd7, b, dn, r);
      total++; if (b !== 8) $display("FAIL udiv_busy_cycles got=%0d exp=8", b); else passed++;
      total++; if (dn !== 9) $display("FAIL udiv_done_cycle got=%0d exp=9", dn); else passed++;
      total++; if (r !== 32'd14) $display("FAIL udiv_quot got=%h exp=%h", r, 32'd14); else passed++;
      total++; if (Done !== 1'b0) $display("FAIL udiv_done_pulse got=%b exp=0", Done); else passed++;
      run_div(1'b0, 1'b1, 32'd100, 32'd7, b, dn, r);
      total++; if (dn !== 9) $display("FAIL urem_done_cycle got=%0d exp=9", dn); else passed++;
      total++; if (r !== 32'd2) $display("FAIL urem_rem got=%h exp=%h", r, 32'd2); else passed++;
      run_div(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, b, dn, r);
      total++; if (r !== 32'd1) $display("FAIL udiv_big_quot got=%h exp=1", r); else passed++;
      run_div(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, b, dn, r);
      total++; if (r !== 32'd1) $display("FAIL udiv_big_rem got=%h exp=1", r); else passed++;
   endtask

   task automatic test_signed();
      int b, dn; logic [31:0] r;
      run_div(1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, b, dn, r);
      total++; if (r !== 32'hFFFFFFFD) $display("FAIL sdiv_quot got=%h exp=FFFFFFFD", r); else passed++;
      run_div(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, b, dn, r);
      total++; if (r !== 32'hFFFFFFFF) $display("FAIL sdiv_rem got=%h exp=FFFFFFFF", r); else passed++;
      run_div(1'b1, 1'b0, 32'd20, 32'hFFFFFFFA, b, dn, r);
      total++; if (r !== 32'hFFFFFFFD) $display("FAIL sdiv_negd_quot got=%h exp=FFFFFFFD", r); else passed++;
      run_div(1'b1, 1'b1, 32'd20, 32'hFFFFFFFA, b, dn, r);
      total++; if (r !== 32'd2) $display("FAIL sdiv_negd_rem got=%h exp=2", r); else passed++;
   endtask

   task automatic test_divzero();
      int b, dn; logic [31:0] r;
      for (int s = 0; s < 2; s++) begin
         run_div(s[0], 1'b0, 32'h00001234, 32'h0, b, dn, r);
         total++; if (dn !== 1) $display("FAIL dz_done_cycle s=%0d got=%0d exp=1", s, dn); else passed++;
         total++; if (b !== 0) $display("FAIL dz_busy s=%0d got=%0d exp=0", s, b); else passed++;
         total++; if (r !== 32'hFFFFFFFF) $display("FAIL dz_quot s=%0d got=%h exp=FFFFFFFF", s, r); else passed++;
         run_div(s[0], 1'b1, 32'h00001234, 32'h0, b, dn, r);
         total++; if (r !== 32'h00001234) $display("FAIL dz_rem s=%0d got=%h exp=00001234", s, r); else passed++;
      end
   endtask

   task automatic test_overflow();
      int b, dn; logic [31:0] r;
      run_div(1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, b, dn, r);
      total++; if (r !== 32'h80000000) $display("FAIL ovf_quot got=%h exp=80000000", r); else passed++;
      run_div(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, b, dn, r);
      total++; if (r !== 32'h0) $display("FAIL ovf_rem got=%h exp=0", r); else passed++;
   endtask

   task automatic test_flush();
      int b, dn, seen; logic [31:0] r;
      run_div(1'b0, 1'b0, 32'd100, 32'd7, b, dn, r);
      Signed = 1'b0; RemOp = 1'b0; X = 32'd50; D = 32'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick(); tick();
      total++; if (Busy !== 1'b1) $display("FAIL flush_pre_busy got=%b exp=1", Busy); else passed++;
      Flush = 1'b1;
      tick();
      Flush = 1'b0;
      total++; if (Busy !== 1'b0) $display("FAIL flush_busy got=%b exp=0", Busy); else passed++;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (Done) seen++;
         tick();
      end
      total++; if (seen !== 0) $display("FAIL flush_no_done got=%0d exp=0", seen); else passed++;
      total++; if (Result !== 32'd14) $display("FAIL flush_result_hold got=%h exp=%h", Result, 32'd14); else passed++;
      Flush = 1'b1; Start = 1'b1; X = 32'd9; D = 32'd3;
      tick();
      Flush = 1'b0; Start = 1'b0;
      total++; if (Busy !== 1'b0 || Done !== 1'b0)
         $display("FAIL flush_over_start got=%b%b exp=00", Busy, Done); else passed++;
      run_div(1'b0, 1'b0, 32'd9, 32'd3, b, dn, r);
      total++; if (dn !== 9) $display("FAIL post_flush_done_cycle got=%0d exp=9", dn); else passed++;
      total++; if (r !== 32'd3) $display("FAIL post_flush_quot got=%h exp=3", r); else passed++;
   endtask

   task automatic test_back_to_back();
      int dn, seen, b; logic [31:0] r;
      Signed = 1'b0; RemOp = 1'b1; X = 32'd100; D = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0; dn = 0; seen = 0;
      for (int c = 1; c <= 25; c++) begin
         if (c == 3) begin Start = 1'b1; X = 32'd50; D = 32'd5; RemOp = 1'b0; end
         else Start = 1'b0;
         if (Done) begin
            if (dn == 0) begin dn = c; r = Result; end
            else seen++;
         end
         tick();
      end
      total++; if (dn !== 9) $display("FAIL extra_start_done_cycle got=%0d exp=9", dn); else passed++;
      total++; if (r !== 32'd2) $display("FAIL extra_start_result got=%h exp=2", r); else passed++;
      total++; if (seen !== 0) $display("FAIL extra_start_queued got=%0d exp=0", seen); else passed++;
      Signed = 1'b0; RemOp = 1'b0; X = 32'd100; D = 32'd7; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick(); tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (Busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", Busy); else passed++;
      total++; if (Result !== 32'h0) $display("FAIL midreset_result got=%h exp=0", Result); else passed++;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         if (Done) seen++;
         tick();
      end
      total++; if (seen !== 0) $display("FAIL midreset_no_done got=%0d exp=0", seen); else passed++;
      run_div(1'b0, 1'b1, 32'd9, 32'd4, b, dn, r);
      total++; if (dn !== 9 || r !== 32'd1)
         $display("FAIL post_reset_op got=%0d/%h exp=9/1", dn, r); else passed++;
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_divzero();
      test_overflow();
      test_flush();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
